// File: rtl/hilo_div_writeback_if.sv
// EX-stage operation bus for the HI/LO / divide writeback block.
// The EX stage drives the op fields; the block returns stall and MF results.
interface hilo_div_writeback_if #(
  parameter int unsigned XLEN = 64
);
  logic            op_valid;
  logic [2:0]      op_code;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            stall;
  logic [XLEN-1:0] mf_data;
  logic            mf_valid;

  modport master (
    output op_valid, op_code, op_a, op_b,
    input  stall, mf_data, mf_valid
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b,
    output stall, mf_data, mf_valid
  );
endinterface

// File: rtl/hilo_div_writeback.sv
// Owns architectural HI/LO; launches the iterative divider with operand
// magnitudes, sign-corrects its result, and services MTHI/MTLO/MFHI/MFLO.
module hilo_div_writeback #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned MAX_WAIT = 80,
  parameter int unsigned CNT_W    = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hilo_div_writeback_if.slave   ex,
  output logic [XLEN-1:0]       div_a,
  output logic [XLEN-1:0]       div_b,
  input  logic [XLEN-1:0]       div_quotient,
  input  logic [XLEN-1:0]       div_remainder,
  input  logic                  div_ready,
  output logic [XLEN-1:0]       hi,
  output logic [XLEN-1:0]       lo,
  output logic                  busy,
  output logic                  dz_err,
  output logic                  to_err
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, WRITE} state_t;

  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ONE      = XLEN'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT);

  state_t          state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic            sq, sr, ovf;
  logic            div_zero;
  logic [XLEN-1:0] abs_a, abs_b, q_mag, q_fix, r_fix;

  always_comb begin
    div_zero = (ex.op_b == '0);
    abs_a    = ex.op_a[XLEN-1] ? -ex.op_a : ex.op_a;
    abs_b    = ex.op_b[XLEN-1] ? -ex.op_b : ex.op_b;
    q_mag    = {1'b0, div_quotient[XLEN-2:0]};
    q_fix    = sq ? -q_mag : q_mag;
    r_fix    = sr ? -div_remainder : div_remainder;
    cnt_inc  = cnt + 1'b1;
    ex.stall = ex.op_valid && (state != IDLE);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (ex.op_valid && ex.op_code == 3'd0 && !div_zero) state_nx = LAUNCH;
      LAUNCH: state_nx = WAIT;
      // cnt counts WAIT cycles already completed; the first WAIT cycle may
      // still see the previous result's ready, so it is never accepted there.
      WAIT:   if (div_ready && cnt != '0)  state_nx = WRITE;
              else if (cnt_inc == CNT_LAST) state_nx = IDLE;
      WRITE:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi          <= '0;
      lo          <= '0;
      div_a       <= '0;
      div_b       <= '0;
      ex.mf_data  <= '0;
      ex.mf_valid <= 1'b0;
      busy        <= 1'b0;
      dz_err      <= 1'b0;
      to_err      <= 1'b0;
      cnt         <= '0;
      sq          <= 1'b0;
      sr          <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      ex.mf_valid <= 1'b0;
      case (state)
        IDLE: if (ex.op_valid) begin
          case (ex.op_code)
            3'd0: if (div_zero) begin
              dz_err <= 1'b1;
            end else begin
              sq    <= ex.op_a[XLEN-1] ^ ex.op_b[XLEN-1];
              sr    <= ex.op_a[XLEN-1];
              // Quotient magnitude 2^(XLEN-1) collides with the divider's
              // sign flag bit, so that one case is resolved here instead.
              ovf   <= (ex.op_a == MOST_NEG) && (abs_b == ONE);
              div_a <= abs_a;
              div_b <= abs_b;
              busy  <= 1'b1;
            end
            3'd1: hi <= ex.op_a;
            3'd2: lo <= ex.op_a;
            3'd3: begin
              ex.mf_data  <= hi;
              ex.mf_valid <= 1'b1;
            end
            3'd4: begin
              ex.mf_data  <= lo;
              ex.mf_valid <= 1'b1;
            end
            default: ;
          endcase
        end
        LAUNCH: cnt <= '0;
        WAIT: begin
          cnt <= cnt_inc;
          if (state_nx == IDLE) begin
            to_err <= 1'b1;
            busy   <= 1'b0;
          end
        end
        WRITE: begin
          lo   <= ovf ? MOST_NEG : q_fix;
          hi   <= ovf ? '0 : r_fix;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_writeback.sv
// Scoreboard bench for hilo_div_writeback with a behavioural divide unit
// that answers a configurable number of cycles after each launch.
module tb_hilo_div_writeback;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic        clk;
  logic        rst_n;
  logic [63:0] div_a, div_b, div_quotient, div_remainder, hi, lo;
  logic        div_ready, busy, dz_err, to_err;

  hilo_div_writeback_if #(.XLEN(64)) ex_if ();

  hilo_div_writeback #(.XLEN(64), .MAX_WAIT(80), .CNT_W(7)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex            (ex_if),
    .div_a         (div_a),
    .div_b         (div_b),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .div_ready     (div_ready),
    .hi            (hi),
    .lo            (lo),
    .busy          (busy),
    .dz_err        (dz_err),
    .to_err        (to_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0]  mf_exp[$];
  logic [127:0] div_exp[$];

  int  ready_delay = 65;
  int  m_cnt = 0;
  bit  m_active = 0;
  bit  busy_prev = 0;
  int  mf_pulses = 0;

  // One clock; the divide-unit model reacts to the launch and answers later.
  task automatic tick();
    @(posedge clk); #1;
    if (busy && !busy_prev) begin
      div_ready = 1'b0;
      m_cnt     = 0;
      m_active  = 1;
    end else if (m_active) begin
      m_cnt++;
      if (m_cnt == ready_delay) begin
        div_quotient  = (div_a / div_b) | MIN64;
        div_remainder = div_a % div_b;
        div_ready     = 1'b1;
        m_active      = 0;
      end
    end
    busy_prev = busy;
    if (ex_if.mf_valid) mf_pulses++;
  endtask

  task automatic do_op(input logic [2:0] c, input logic [63:0] a, input logic [63:0] b,
                       output int waited);
    ex_if.op_valid = 1'b1;
    ex_if.op_code  = c;
    ex_if.op_a     = a;
    ex_if.op_b     = b;
    #1;
    waited = 0;
    while (ex_if.stall && waited < 300) begin
      tick();
      waited++;
    end
    checks++;
    if (ex_if.stall !== 1'b0) begin
      errors++;
      $display("FAIL op_accept: stall=%b after %0d cycles, required 0", ex_if.stall, waited);
    end
    tick();
    ex_if.op_valid = 1'b0;
  endtask

  task automatic run_div(input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_hi, input logic [63:0] exp_lo,
                         output int busy_cycles);
    logic [63:0]  exp_da, exp_db;
    logic [127:0] exp;
    int w;
    exp_da = a[63] ? -a : a;
    exp_db = b[63] ? -b : b;
    div_exp.push_back({exp_hi, exp_lo});
    do_op(3'd0, a, b, w);
    checks++;
    if ({div_a, div_b, busy} !== {exp_da, exp_db, 1'b1}) begin
      errors++;
      $display("FAIL launch_operands: div_a=%h div_b=%h busy=%b required %h %h 1",
               div_a, div_b, busy, exp_da, exp_db);
    end
    busy_cycles = 1;
    while (busy && busy_cycles < 300) begin
      tick();
      busy_cycles++;
    end
    busy_cycles--;
    exp = div_exp.pop_front();
    checks++;
    if (busy !== 1'b0 || {hi, lo} !== exp) begin
      errors++;
      $display("FAIL div_result: busy=%b hi=%h lo=%h required busy=0 hi=%h lo=%h",
               busy, hi, lo, exp[127:64], exp[63:0]);
    end
  endtask

  task automatic test_reset();
    int w;
    logic [63:0] e;
    rst_n = 1'b0;
    ex_if.op_valid = 1'b0; ex_if.op_code = '0; ex_if.op_a = '0; ex_if.op_b = '0;
    div_ready = 1'b0; div_quotient = '0; div_remainder = '0;
    #12;
    checks++;
    if ({hi, lo, div_a, div_b, ex_if.mf_data} !== '0 ||
        {busy, dz_err, to_err, ex_if.mf_valid, ex_if.stall} !== 5'b0) begin
      errors++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b dz=%b to=%b mfv=%b required all 0",
               hi, lo, busy, dz_err, to_err, ex_if.mf_valid);
    end
    rst_n = 1'b1;
    tick();
    mf_exp.push_back(64'd0);
    do_op(3'd4, '0, '0, w);
    e = mf_exp.pop_front();
    checks++;
    if (ex_if.mf_valid !== 1'b1 || ex_if.mf_data !== e) begin
      errors++;
      $display("FAIL mflo_after_reset: mf_valid=%b mf_data=%h required 1 %h",
               ex_if.mf_valid, ex_if.mf_data, e);
    end
    tick();
    checks++;
    if (ex_if.mf_valid !== 1'b0) begin
      errors++;
      $display("FAIL mf_pulse_width: mf_valid=%b required 0", ex_if.mf_valid);
    end
  endtask

  task automatic test_div();
    int bc;
    ready_delay = 65;
    run_div(64'd100, 64'd7, 64'd2, 64'd14, bc);
    checks++;
    if (bc !== 67) begin
      errors++;
      $display("FAIL busy_duration: busy for %0d cycles, required 67", bc);
    end
  endtask

  task automatic test_signed();
    int bc;
    longint sa, sb;
    sa = -100; sb = 7;
    run_div(64'(sa), 64'(sb), 64'(sa % sb), 64'(sa / sb), bc);
    sa = 100; sb = -7;
    run_div(64'(sa), 64'(sb), 64'(sa % sb), 64'(sa / sb), bc);
    sa = -1000; sb = -33;
    run_div(64'(sa), 64'(sb), 64'(sa % sb), 64'(sa / sb), bc);
    run_div(MIN64, '1, 64'd0, MIN64, bc);
    checks++;
    if ({dz_err, to_err} !== 2'b00) begin
      errors++;
      $display("FAIL min_div_flags: dz=%b to=%b required 0 0", dz_err, to_err);
    end
  endtask

  task automatic test_div_by_zero();
    int w;
    logic [63:0] e;
    do_op(3'd1, 64'hAAAA, '0, w);
    do_op(3'd2, 64'h5555, '0, w);
    ex_if.op_valid = 1'b1; ex_if.op_code = 3'd0; ex_if.op_a = 64'd77; ex_if.op_b = '0;
    #1;
    checks++;
    if (ex_if.stall !== 1'b0) begin
      errors++;
      $display("FAIL dz_no_stall: stall=%b required 0", ex_if.stall);
    end
    tick();
    ex_if.op_valid = 1'b0;
    tick();
    checks++;
    if ({dz_err, busy, hi, lo} !== {1'b1, 1'b0, 64'hAAAA, 64'h5555}) begin
      errors++;
      $display("FAIL div_by_zero: dz=%b busy=%b hi=%h lo=%h required 1 0 aaaa 5555",
               dz_err, busy, hi, lo);
    end
    mf_exp.push_back(64'hAAAA);
    do_op(3'd3, '0, '0, w);
    e = mf_exp.pop_front();
    checks++;
    if (ex_if.mf_valid !== 1'b1 || ex_if.mf_data !== e) begin
      errors++;
      $display("FAIL mfhi: mf_valid=%b mf_data=%h required 1 %h", ex_if.mf_valid, ex_if.mf_data, e);
    end
  endtask

  task automatic test_mf_during_div();
    int w;
    longint sa, sb;
    logic [63:0] e;
    sa = 1000; sb = -3;
    ready_delay = 65;
    do_op(3'd0, 64'(sa), 64'(sb), w);
    mf_pulses = 0;
    mf_exp.push_back(64'(sa / sb));
    do_op(3'd4, '0, '0, w);
    checks++;
    if (w !== 67) begin
      errors++;
      $display("FAIL stall_cycles: stalled %0d cycles, required 67", w);
    end
    e = mf_exp.pop_front();
    checks++;
    if (ex_if.mf_valid !== 1'b1 || ex_if.mf_data !== e || hi !== 64'(sa % sb)) begin
      errors++;
      $display("FAIL mflo_after_write: mf_valid=%b mf_data=%h hi=%h required 1 %h %h",
               ex_if.mf_valid, ex_if.mf_data, hi, e, 64'(sa % sb));
    end
    tick();
    tick();
    checks++;
    if (mf_pulses !== 1) begin
      errors++;
      $display("FAIL mf_pulse_count: %0d pulses, required 1", mf_pulses);
    end
  endtask

  task automatic test_stray_ready();
    logic [63:0] hi0, lo0;
    hi0 = hi; lo0 = lo;
    div_quotient = 64'd123; div_remainder = 64'd45; div_ready = 1'b1;
    tick(); tick(); tick();
    div_ready = 1'b0;
    tick();
    checks++;
    if ({busy, hi, lo} !== {1'b0, hi0, lo0}) begin
      errors++;
      $display("FAIL stray_ready: busy=%b hi=%h lo=%h required 0 %h %h", busy, hi, lo, hi0, lo0);
    end
  endtask

  task automatic test_timeout();
    int w, n;
    logic [63:0] hi0, lo0;
    hi0 = hi; lo0 = lo;
    ready_delay = 100000;
    do_op(3'd0, 64'd50, 64'd5, w);
    n = 0;
    while (!to_err && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (to_err !== 1'b1 || n < 80 || n > 82) begin
      errors++;
      $display("FAIL timeout_timing: to_err=%b after %0d cycles, required 1 after 80..82", to_err, n);
    end
    checks++;
    if ({busy, hi, lo} !== {1'b0, hi0, lo0}) begin
      errors++;
      $display("FAIL timeout_state: busy=%b hi=%h lo=%h required 0 %h %h", busy, hi, lo, hi0, lo0);
    end
    tick(); tick();
    checks++;
    if ({to_err, dz_err} !== 2'b11) begin
      errors++;
      $display("FAIL sticky_flags: to=%b dz=%b required 1 1", to_err, dz_err);
    end
  endtask

  task automatic test_reset_mid_wait();
    int w;
    ready_delay = 65;
    do_op(3'd0, 64'd9, 64'd2, w);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({hi, lo, div_a, div_b, ex_if.mf_data} !== '0 ||
        {busy, dz_err, to_err, ex_if.mf_valid, ex_if.stall} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: hi=%h lo=%h busy=%b dz=%b to=%b required all 0",
               hi, lo, busy, dz_err, to_err);
    end
    #3;
    rst_n = 1'b1;
    m_active = 0;
    div_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, hi, lo} !== '0) begin
      errors++;
      $display("FAIL after_reset_idle: busy=%b hi=%h lo=%h required 0", busy, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_div();
    test_signed();
    test_div_by_zero();
    test_mf_during_div();
    test_stray_ready();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
